// File: rtl/fp_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_param
// Brief    : Multi-cycle IEEE-754 adder/subtractor, RNE rounding, subnormals,
//            valid/ready handshake on both sides, exception flags.
// Revision : 1.0
// ============================================================================
module fp_addsub_param #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic [EXP_W+MAN_W:0]   input_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic [3:0]             flags
);
    localparam int c_W   = 1 + EXP_W + MAN_W;
    localparam int c_MW  = MAN_W + 4;            // hidden + fraction + G,R,S
    localparam int c_EW  = EXP_W + 1;            // exponent with overflow headroom
    localparam int c_LZW = $clog2(c_MW + 1);
    localparam logic [EXP_W-1:0] c_EXP_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
    } state_t;

    state_t r_state, w_next;

    logic [c_W-1:0]   r_a, r_b, r_z, r_res_z;
    logic             r_op, r_out_valid;
    logic [3:0]       r_flags, r_res_f;
    logic             r_sa, r_sb, r_sl, r_ss, r_sign, r_zsign;
    logic [EXP_W-1:0] r_ea, r_eb, r_el;
    logic [c_MW-1:0]  r_ma, r_mb, r_ml, r_ms, r_nm;
    logic [c_MW:0]    r_sum;
    logic [c_EW-1:0]  r_e, r_ne;

    // ---------------- unpack ----------------
    logic [EXP_W-1:0] w_ea_f, w_eb_f, w_ea, w_eb;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_sb, w_invalid, w_special;
    logic [c_MW-1:0]  w_ma, w_mb;
    logic [c_W-1:0]   w_spec_z;

    assign w_ea_f    = r_a[c_W-2:MAN_W];
    assign w_eb_f    = r_b[c_W-2:MAN_W];
    assign w_nan_a   = (&w_ea_f) & (|r_a[MAN_W-1:0]);
    assign w_nan_b   = (&w_eb_f) & (|r_b[MAN_W-1:0]);
    assign w_inf_a   = (&w_ea_f) & ~(|r_a[MAN_W-1:0]);
    assign w_inf_b   = (&w_eb_f) & ~(|r_b[MAN_W-1:0]);
    assign w_sb      = r_b[c_W-1] ^ (r_op & ~w_nan_b);
    assign w_ea      = (w_ea_f == '0) ? EXP_W'(1) : w_ea_f;
    assign w_eb      = (w_eb_f == '0) ? EXP_W'(1) : w_eb_f;
    assign w_ma      = {|w_ea_f, r_a[MAN_W-1:0], 3'b000};
    assign w_mb      = {|w_eb_f, r_b[MAN_W-1:0], 3'b000};
    assign w_invalid = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (r_a[c_W-1] != w_sb));
    assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
    assign w_spec_z  = w_invalid ? {1'b0, c_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}}
                                 : {(w_inf_a ? r_a[c_W-1] : w_sb), c_EXP_ONES, {MAN_W{1'b0}}};

    // ---------------- align ----------------
    logic             w_a_big, w_far, w_lost;
    logic [EXP_W-1:0] w_el, w_es, w_diff;
    logic [c_MW-1:0]  w_ml, w_mx, w_shifted, w_ms;

    assign w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_el      = w_a_big ? r_ea : r_eb;
    assign w_es      = w_a_big ? r_eb : r_ea;
    assign w_ml      = w_a_big ? r_ma : r_mb;
    assign w_mx      = w_a_big ? r_mb : r_ma;
    assign w_diff    = w_el - w_es;
    assign w_far     = w_diff >= EXP_W'(MAN_W + 3);
    assign w_shifted = w_mx >> w_diff;
    assign w_lost    = |(w_mx & ~({c_MW{1'b1}} << w_diff));
    assign w_ms      = w_far ? {{(c_MW-1){1'b0}}, |w_mx}
                             : {w_shifted[c_MW-1:1], w_shifted[0] | w_lost};

    // ---------------- add ----------------
    logic [c_MW:0] w_sum;
    assign w_sum = (r_sl == r_ss) ? ({1'b0, r_ml} + {1'b0, r_ms})
                                  : ({1'b0, r_ml} - {1'b0, r_ms});

    // ---------------- normalise ----------------
    logic [c_LZW-1:0] w_lz;
    logic [c_EW-1:0]  w_lim, w_sh, w_ne;
    logic [c_MW-1:0]  w_nm;

    always_comb begin
        w_lz = c_LZW'(c_MW);
        for (int i = 0; i < c_MW; i++)
            if (r_sum[i]) w_lz = c_LZW'(c_MW - 1 - i);
        // left shift never takes the exponent below 1; leftover is subnormal
        w_lim = r_e - c_EW'(1);
        w_sh  = (c_EW'(w_lz) > w_lim) ? w_lim : c_EW'(w_lz);
        if (r_sum[c_MW]) begin
            w_nm = {r_sum[c_MW:2], r_sum[1] | r_sum[0]};
            w_ne = r_e + c_EW'(1);
        end else begin
            w_nm = r_sum[c_MW-1:0] << w_sh;
            w_ne = r_e - w_sh;
        end
    end

    // ---------------- round / pack ----------------
    logic               w_inexact, w_inc, w_hid, w_ovf, w_zero, w_rsign;
    logic [MAN_W+1:0]   w_rm;
    logic [MAN_W-1:0]   w_frac;
    logic [c_EW-1:0]    w_re;
    logic [c_W-1:0]     w_round_z;
    logic [3:0]         w_round_f;

    assign w_inexact = r_nm[2] | r_nm[1] | r_nm[0];
    assign w_inc     = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    assign w_rm      = {1'b0, r_nm[c_MW-1:3]} + (MAN_W+2)'(w_inc);
    assign w_hid     = w_rm[MAN_W+1] | w_rm[MAN_W];
    assign w_frac    = w_rm[MAN_W+1] ? w_rm[MAN_W:1] : w_rm[MAN_W-1:0];
    assign w_re      = w_rm[MAN_W+1] ? (r_ne + c_EW'(1)) : r_ne;
    assign w_ovf     = w_hid & (w_re >= {1'b0, c_EXP_ONES});
    assign w_zero    = ~(|r_nm);
    assign w_rsign   = w_zero ? r_zsign : r_sign;

    always_comb begin
        if (w_ovf) begin
            w_round_z = {r_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_round_f = 4'b0101;
        end else begin
            w_round_z = {w_rsign, (w_hid ? w_re[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
            w_round_f = {2'b00, ~w_hid & w_inexact, w_inexact};
        end
    end

    // ---------------- control ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_UNPACK;
            S_UNPACK: w_next = w_special ? S_OUT : S_ALIGN;
            S_ALIGN:  w_next = S_ADD;
            S_ADD:    w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_OUT;
            S_OUT:    if (r_out_valid && out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_flags     <= '0;
        end else begin
            r_state <= w_next;
            // first OUT cycle publishes the result; it then holds until taken
            if (r_state == S_OUT && !r_out_valid) begin
                r_out_valid <= 1'b1;
                r_z         <= r_res_z;
                r_flags     <= r_res_f;
            end else if (r_state == S_OUT && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (in_valid) begin
                r_a  <= input_a;
                r_b  <= input_b;
                r_op <= op;
            end
            S_UNPACK: begin
                r_sa    <= r_a[c_W-1];
                r_sb    <= w_sb;
                r_ea    <= w_ea;
                r_eb    <= w_eb;
                r_ma    <= w_ma;
                r_mb    <= w_mb;
                r_res_z <= w_spec_z;
                r_res_f <= {w_invalid, 3'b000};
            end
            S_ALIGN: begin
                r_sl <= w_a_big ? r_sa : r_sb;
                r_ss <= w_a_big ? r_sb : r_sa;
                r_el <= w_el;
                r_ml <= w_ml;
                r_ms <= w_ms;
            end
            S_ADD: begin
                r_sum   <= w_sum;
                r_e     <= {1'b0, r_el};
                r_sign  <= r_sl;
                r_zsign <= r_sl & r_ss;
            end
            S_NORM: begin
                r_nm <= w_nm;
                r_ne <= w_ne;
            end
            S_ROUND: begin
                r_res_z <= w_round_z;
                r_res_f <= w_round_f;
            end
            default: ;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign output_z  = r_z;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_param
// Brief    : Directed bench for fp_addsub_param in double and single format.
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rset;
    logic        d_in_valid, d_in_ready, d_op, d_out_valid, d_out_ready;
    logic [63:0] d_a, d_b, d_z;
    logic [3:0]  d_flags;
    logic        s_in_valid, s_in_ready, s_op, s_out_valid, s_out_ready;
    logic [31:0] s_a, s_b, s_z;
    logic [3:0]  s_flags;

    int n_tests = 0;
    int n_fail  = 0;

    fp_addsub_param #(.EXP_W(11), .MAN_W(52)) u_dut_d (
        .clk(clk), .rset(rset), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op(d_op), .input_a(d_a), .input_b(d_b), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .output_z(d_z), .flags(d_flags)
    );

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) u_dut_s (
        .clk(clk), .rset(rset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .input_a(s_a), .input_b(s_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .output_z(s_z), .flags(s_flags)
    );

    // Issue one operation on the selected instance, return result and latency.
    task automatic run(input bit sp, input logic [63:0] a, input logic [63:0] b,
                       input logic opi, output logic [63:0] z, output logic [3:0] f,
                       output int lat);
        int n;
        @(negedge clk);
        if (sp) begin s_a = a[31:0]; s_b = b[31:0]; s_op = opi; s_in_valid = 1'b1; end
        else    begin d_a = a;       d_b = b;       d_op = opi; d_in_valid = 1'b1; end
        n = 0;
        while (!(sp ? s_in_ready : d_in_ready) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        d_in_valid = 1'b0;
        lat = 0;
        while (!(sp ? s_out_valid : d_out_valid) && lat < 40) begin @(posedge clk); #1; lat++; end
        z = sp ? {32'h0, s_z} : d_z;
        f = sp ? s_flags : d_flags;
        @(negedge clk);
        s_out_ready = sp;
        d_out_ready = !sp;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        d_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (d_in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", d_in_ready); end
        n_tests++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", d_out_valid); end
        n_tests++; if (d_z !== 64'h0)        begin n_fail++; $display("FAIL reset_z: got %h want 0", d_z); end
        n_tests++; if (d_flags !== 4'h0)     begin n_fail++; $display("FAIL reset_flags: got %b want 0000", d_flags); end
        n_tests++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_z !== 32'h0)
            begin n_fail++; $display("FAIL reset_single: got rdy=%b vld=%b z=%h want 1 0 0", s_in_ready, s_out_valid, s_z); end
        @(negedge clk);
        rset = 1'b1;
    endtask

    task automatic test_add();
        logic [63:0] z; logic [3:0] f; int lat;
        run(1'b0, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, z, f, lat);
        n_tests++; if (z !== 64'h4008000000000000) begin n_fail++; $display("FAIL add_z: got %h want 4008000000000000", z); end
        n_tests++; if (f !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b want 0000", f); end
        n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL add_latency: got %0d want 6", lat); end
        run(1'b0, 64'h0000000000000000, 64'h3FF8000000000000, 1'b0, z, f, lat);
        n_tests++; if (z !== 64'h3FF8000000000000 || f !== 4'b0000)
            begin n_fail++; $display("FAIL zero_plus_x: got %h/%b want 3FF8000000000000/0000", z, f); end
        run(1'b0, 64'hC008000000000000, 64'h0000000000000000, 1'b1, z, f, lat);
        n_tests++; if (z !== 64'hC008000000000000 || f !== 4'b0000)
            begin n_fail++; $display("FAIL x_minus_zero: got %h/%b want C008000000000000/0000", z, f); end
    endtask

    task automatic test_zero();
        logic [63:0] z; logic [3:0] f; int lat;
        run(1'b0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, z, f, lat);
        n_tests++; if (z !== 64'h0 || f !== 4'b0000)
            begin n_fail++; $display("FAIL cancel_zero: got %h/%b want 0000000000000000/0000", z, f); end
        run(1'b0, 64'h8000000000000000, 64'h8000000000000000, 1'b0, z, f, lat);
        n_tests++; if (z !== 64'h8000000000000000 || f !== 4'b0000)
            begin n_fail++; $display("FAIL neg_zero: got %h/%b want 8000000000000000/0000", z, f); end
    endtask

    task automatic test_special();
        logic [63:0] z; logic [3:0] f; int lat;
        run(1'b0, 64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, z, f, lat);
        n_tests++; if (z !== 64'h7FF8000000000000) begin n_fail++; $display("FAIL inf_minus_inf_z: got %h want 7FF8000000000000", z); end
        n_tests++; if (f !== 4'b1000) begin n_fail++; $display("FAIL inf_minus_inf_flags: got %b want 1000", f); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL special_latency: got %0d want 2", lat); end
        run(1'b0, 64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, z, f, lat);
        n_tests++; if (z !== 64'h7FF8000000000000 || f !== 4'b1000)
            begin n_fail++; $display("FAIL nan_in: got %h/%b want 7FF8000000000000/1000", z, f); end
        run(1'b0, 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b1, z, f, lat);
        n_tests++; if (z !== 64'hFFF0000000000000 || f !== 4'b0000)
            begin n_fail++; $display("FAIL x_minus_inf: got %h/%b want FFF0000000000000/0000", z, f); end
    endtask

    task automatic test_boundary();
        logic [63:0] z; logic [3:0] f; int lat;
        run(1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, z, f, lat);
        n_tests++; if (z !== 64'h7FF0000000000000) begin n_fail++; $display("FAIL overflow_z: got %h want 7FF0000000000000", z); end
        n_tests++; if (f !== 4'b0101) begin n_fail++; $display("FAIL overflow_flags: got %b want 0101", f); end
        run(1'b0, 64'h0010000000000000, 64'h000FFFFFFFFFFFFF, 1'b1, z, f, lat);
        n_tests++; if (z !== 64'h0000000000000001 || f !== 4'b0000)
            begin n_fail++; $display("FAIL subnormal_diff: got %h/%b want 0000000000000001/0000", z, f); end
    endtask

    task automatic test_single();
        logic [63:0] z; logic [3:0] f; int lat;
        run(1'b1, 64'h3F800000, 64'h33800000, 1'b0, z, f, lat);
        n_tests++; if (z[31:0] !== 32'h3F800000 || f !== 4'b0001)
            begin n_fail++; $display("FAIL sp_tie_even: got %h/%b want 3F800000/0001", z[31:0], f); end
        run(1'b1, 64'h3F800000, 64'h34000000, 1'b0, z, f, lat);
        n_tests++; if (z[31:0] !== 32'h3F800001 || f !== 4'b0000)
            begin n_fail++; $display("FAIL sp_lsb: got %h/%b want 3F800001/0000", z[31:0], f); end
        run(1'b1, 64'h3F800001, 64'h33800000, 1'b0, z, f, lat);
        n_tests++; if (z[31:0] !== 32'h3F800002 || f !== 4'b0001)
            begin n_fail++; $display("FAIL sp_tie_odd: got %h/%b want 3F800002/0001", z[31:0], f); end
        n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL sp_latency: got %0d want 6", lat); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        @(negedge clk);
        d_a = 64'h3FF0000000000000; d_b = 64'h4000000000000000; d_op = 1'b0; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        n = 0;
        while (!d_out_valid && n < 40) begin @(posedge clk); #1; n++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (d_z !== 64'h4008000000000000 || d_flags !== 4'b0000 || d_in_ready !== 1'b0 || d_out_valid !== 1'b1) bad++;
        end
        n_tests++; if (bad !== 0)
            begin n_fail++; $display("FAIL backpressure_hold: got %0d unstable cycles (z=%h) want 0", bad, d_z); end
        @(negedge clk); d_out_ready = 1'b1;
        @(posedge clk); #1; d_out_ready = 1'b0;
        n_tests++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1)
            begin n_fail++; $display("FAIL after_transfer: got vld=%b rdy=%b want 0 1", d_out_valid, d_in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] z; logic [3:0] f; int lat;
        int seen;
        @(negedge clk);
        d_a = 64'h3FF0000000000000; d_b = 64'h4000000000000000; d_op = 1'b0; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rset = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0)
            begin n_fail++; $display("FAIL reset_mid: got rdy=%b vld=%b want 1 0", d_in_ready, d_out_valid); end
        @(negedge clk); rset = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (d_out_valid) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL reset_dropped: got %0d valid cycles want 0", seen); end
        run(1'b0, 64'h4000000000000000, 64'h3FF0000000000000, 1'b1, z, f, lat);
        n_tests++; if (z !== 64'h3FF0000000000000 || f !== 4'b0000)
            begin n_fail++; $display("FAIL after_reset_op: got %h/%b want 3FF0000000000000/0000", z, f); end
    endtask

    initial begin
        rset = 1'b0;
        d_in_valid = 1'b0; d_op = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0;
        s_in_valid = 1'b0; s_op = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0;
        test_reset();
        test_add();
        test_zero();
        test_special();
        test_boundary();
        test_single();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
